// File: rtl/tl_pkg.sv
// Shared phase encodings, lamp patterns and the per-phase lamp decode
// used by the two-road traffic-light sequencer.
`timescale 1ns/1ps
package tl_pkg;

    localparam logic [2:0] AG    = 3'd0;
    localparam logic [2:0] AY    = 3'd1;
    localparam logic [2:0] AR    = 3'd2;
    localparam logic [2:0] BG    = 3'd3;
    localparam logic [2:0] BY    = 3'd4;
    localparam logic [2:0] BR    = 3'd5;
    localparam logic [2:0] NIGHT = 3'd6;

    localparam logic [2:0] LAMP_R   = 3'b100;
    localparam logic [2:0] LAMP_Y   = 3'b010;
    localparam logic [2:0] LAMP_G   = 3'b001;
    localparam logic [2:0] LAMP_OFF = 3'b000;

    // Returns {road A lamps, road B lamps}; NIGHT flashing is applied by the caller.
    function automatic logic [5:0] lamp_decode(input logic [2:0] st);
        logic [5:0] lamps;
        case (st)
            AG:      lamps = {LAMP_G, LAMP_R};
            AY:      lamps = {LAMP_Y, LAMP_R};
            AR:      lamps = {LAMP_R, LAMP_R};
            BG:      lamps = {LAMP_R, LAMP_G};
            BY:      lamps = {LAMP_R, LAMP_Y};
            BR:      lamps = {LAMP_R, LAMP_R};
            default: lamps = {LAMP_OFF, LAMP_OFF};
        endcase
        return lamps;
    endfunction

endpackage

// File: rtl/tl_tick_gen.sv
// Free-running prescaler producing a one-cycle tick every CLK_DIV clocks and
// a registered flag marking the first half of each period.
`timescale 1ns/1ps
module tl_tick_gen #(
    parameter int CLK_DIV = 50000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    output logic tick_o,
    output logic first_half_o
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] HALF = CW'(CLK_DIV / 2);

    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;
    logic          half_reg;

    always_comb begin
        count_next = count_reg + 1'b1;
        if (clr_i || count_reg == LAST) begin
            count_next = '0;
        end
    end

    // The half flag is registered from the next count so it lines up with count_reg.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
            half_reg  <= 1'b1;
        end else begin
            count_reg <= count_next;
            half_reg  <= (count_next < HALF);
        end
    end

    assign tick_o       = (count_reg == LAST);
    assign first_half_o = half_reg;

endmodule

// File: rtl/tl_phase_sequencer.sv
// Two-road traffic-light phase sequencer with per-road adjustable green time
// and a flashing-yellow night mode.
`timescale 1ns/1ps
module tl_phase_sequencer
    import tl_pkg::*;
#(
    parameter int CLK_DIV   = 50000000,
    parameter int CNT_W     = 8,
    parameter int GREEN_DEF = 30,
    parameter int YELLOW_T  = 3,
    parameter int ALLRED_T  = 2,
    parameter int GREEN_MIN = 5,
    parameter int GREEN_MAX = 99
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             night_i,
    input  logic             plus_i,
    input  logic             sub_i,
    input  logic             adj_sel_i,
    output logic [2:0]       lamp_a_o,
    output logic [2:0]       lamp_b_o,
    output logic [CNT_W-1:0] remain_o,
    output logic [2:0]       phase_o,
    output logic [CNT_W-1:0] green_a_o,
    output logic [CNT_W-1:0] green_b_o,
    output logic             sec_tick_o
);

    localparam logic [CNT_W-1:0] GREEN_DEF_W = CNT_W'(GREEN_DEF);
    localparam logic [CNT_W-1:0] YELLOW_W    = CNT_W'(YELLOW_T);
    localparam logic [CNT_W-1:0] ALLRED_W    = CNT_W'(ALLRED_T);
    localparam logic [CNT_W-1:0] GREEN_MIN_W = CNT_W'(GREEN_MIN);
    localparam logic [CNT_W-1:0] GREEN_MAX_W = CNT_W'(GREEN_MAX);
    localparam logic [CNT_W-1:0] ONE_W       = CNT_W'(1);

    logic [2:0]       state_reg;
    logic [2:0]       state_next;
    logic [CNT_W-1:0] remain_reg;
    logic [CNT_W-1:0] remain_next;
    logic [2:0]       lamp_a_reg;
    logic [2:0]       lamp_b_reg;
    logic             presc_clr;
    logic             tick;
    logic             first_half;
    logic [CNT_W-1:0] green_cur [2];

    tl_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_gen (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr_i        (presc_clr),
        .tick_o       (tick),
        .first_half_o (first_half)
    );

    // Night entry outranks any pending phase advance; loads use pre-adjust green values.
    always_comb begin
        state_next  = state_reg;
        remain_next = remain_reg;
        presc_clr   = 1'b0;
        if (state_reg != NIGHT) begin
            if (night_i) begin
                state_next  = NIGHT;
                remain_next = '0;
                presc_clr   = 1'b1;
            end else if (tick) begin
                if (remain_reg > ONE_W) begin
                    remain_next = remain_reg - ONE_W;
                end else begin
                    case (state_reg)
                        AG: begin
                            state_next  = AY;
                            remain_next = YELLOW_W;
                        end
                        AY: begin
                            state_next  = AR;
                            remain_next = ALLRED_W;
                        end
                        AR: begin
                            state_next  = BG;
                            remain_next = green_cur[1];
                        end
                        BG: begin
                            state_next  = BY;
                            remain_next = YELLOW_W;
                        end
                        BY: begin
                            state_next  = BR;
                            remain_next = ALLRED_W;
                        end
                        default: begin
                            state_next  = AG;
                            remain_next = green_cur[0];
                        end
                    endcase
                end
            end
        end else if (!night_i) begin
            state_next  = BR;
            remain_next = ALLRED_W;
            presc_clr   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= AG;
            remain_reg <= GREEN_DEF_W;
            lamp_a_reg <= LAMP_G;
            lamp_b_reg <= LAMP_R;
        end else begin
            state_reg                <= state_next;
            remain_reg               <= remain_next;
            {lamp_a_reg, lamp_b_reg} <= lamp_decode(state_next);
        end
    end

    // One saturating green-time register per road; index 0 is road A.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_road
            logic [CNT_W-1:0] green_reg;
            logic             sel;

            assign sel = (adj_sel_i == 1'(gi));

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    green_reg <= GREEN_DEF_W;
                end else if (sel && plus_i && !sub_i) begin
                    if (green_reg < GREEN_MAX_W) begin
                        green_reg <= green_reg + ONE_W;
                    end
                end else if (sel && sub_i && !plus_i) begin
                    if (green_reg > GREEN_MIN_W) begin
                        green_reg <= green_reg - ONE_W;
                    end
                end
            end

            assign green_cur[gi] = green_reg;
        end
    endgenerate

    assign lamp_a_o   = (state_reg == NIGHT) ? (LAMP_Y & {3{first_half}}) : lamp_a_reg;
    assign lamp_b_o   = (state_reg == NIGHT) ? (LAMP_Y & {3{first_half}}) : lamp_b_reg;
    assign remain_o   = remain_reg;
    assign phase_o    = state_reg;
    assign green_a_o  = green_cur[0];
    assign green_b_o  = green_cur[1];
    assign sec_tick_o = tick;

endmodule
